// File: rtl/regf_arbiter.sv
// Two-requester arbiter in front of a single-ported register file, with ack timeout.
// Define REGF_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: requester 0 has priority).
//
// state | meaning
// IDLE  | waiting for req0/req1, winner and payload latched on exit
// ISSUE | out_regf_req held high until regf_ack or timer expiry
// DONE  | one-cycle ack (and err if timed out) to the winner
module regf_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  rw0,
    input  logic                  rw1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  out_ack0,
    output logic                  out_ack1,
    output logic                  out_err0,
    output logic                  out_err1,
    output logic [DATA_WIDTH-1:0] out_rdata0,
    output logic [DATA_WIDTH-1:0] out_rdata1,
    output logic                  out_regf_req,
    output logic                  out_regf_rw,
    output logic [ADDR_WIDTH-1:0] out_regf_addr,
    output logic [DATA_WIDTH-1:0] out_regf_write_data,
    input  logic                  regf_ack,
    input  logic [DATA_WIDTH-1:0] regf_read_data,
    output logic                  out_busy,
    output logic                  out_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] timer;
    logic       err_q;
    logic       win;

`ifdef REGF_ARB_ROUND_ROBIN_EN
    logic rr_ptr;   // requester preferred on the next tie

    always_comb begin
        win = 1'b0;
        if (req0 && req1)
            win = rr_ptr;
        else
            win = !req0;
    end
`else
    always_comb begin
        win = !req0;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = ISSUE;
            ISSUE:   if (regf_ack || timer == TIMER_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            timer               <= '0;
            err_q               <= 1'b0;
            out_grant           <= 1'b0;
            out_regf_rw         <= 1'b0;
            out_regf_addr       <= '0;
            out_regf_write_data <= '0;
            out_rdata0          <= '0;
            out_rdata1          <= '0;
`ifdef REGF_ARB_ROUND_ROBIN_EN
            rr_ptr              <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        out_grant           <= win;
                        out_regf_rw         <= win ? rw1 : rw0;
                        out_regf_addr       <= win ? addr1 : addr0;
                        out_regf_write_data <= win ? wdata1 : wdata0;
                        timer               <= '0;
                        err_q               <= 1'b0;
                    end
                end
                ISSUE: begin
                    timer <= timer + 8'd1;
                    // ack beats expiry when both land in the same cycle
                    if (regf_ack) begin
                        err_q <= 1'b0;
                        if (!out_regf_rw) begin
                            if (out_grant)
                                out_rdata1 <= regf_read_data;
                            else
                                out_rdata0 <= regf_read_data;
                        end
                    end else if (timer == TIMER_LAST) begin
                        err_q <= 1'b1;
                    end
                end
                DONE: begin
`ifdef REGF_ARB_ROUND_ROBIN_EN
                    rr_ptr <= !out_grant;
`endif
                end
                default: ;
            endcase
        end
    end

    assign out_regf_req = (state == ISSUE);
    assign out_busy     = (state != IDLE);
    assign out_ack0     = (state == DONE) && !out_grant;
    assign out_ack1     = (state == DONE) && out_grant;
    assign out_err0     = out_ack0 && err_q;
    assign out_err1     = out_ack1 && err_q;

endmodule

// File: doc/regf_arbiter.md
REGF_ARBITER -- requirements
Module: regf_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: register data width.
REQ-002 Parameter ADDR_WIDTH, default 4: register address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 15: maximum cycles to wait for regf_ack, legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req0 / req1  input  1  request from requester 0 (I2C slave controller) / requester 1 (local host).
REQ-007 rw0 / rw1  input  1  1 = write, 0 = read.
REQ-008 addr0 / addr1  input  ADDR_WIDTH  register address.
REQ-009 wdata0 / wdata1  input  DATA_WIDTH  write data.
REQ-010 out_ack0 / out_ack1  output  1  one-cycle completion pulse per requester.
REQ-011 out_err0 / out_err1  output  1  one-cycle timeout pulse, coincident with the matching out_ackN.
REQ-012 out_rdata0 / out_rdata1  output  DATA_WIDTH  read data, valid with out_ackN and held until the next completion to that requester.
REQ-013 out_regf_req, out_regf_rw  output  1  request and direction to the register file.
REQ-014 out_regf_addr  output  ADDR_WIDTH; out_regf_write_data  output  DATA_WIDTH.
REQ-015 regf_ack  input  1; regf_read_data  input  DATA_WIDTH  register file response.
REQ-016 out_busy  output  1  high in any state other than IDLE; out_grant  output  1  index of the current or last owner.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, ISSUE and DONE, held in registered state.
REQ-018 IDLE: if req0 or req1 is high, SHALL select a winner, latch its rw, addr and wdata, set out_grant, clear the timer, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-019 ISSUE: SHALL drive out_regf_req=1 with the latched rw, addr and data held stable, and increment the timer each cycle.
REQ-020 ISSUE with regf_ack=1: SHALL capture regf_read_data (reads only) into the winner's out_rdataN and go to DONE with no error.
REQ-021 ISSUE with timer=TIMEOUT_CYCLES-1 and regf_ack=0: SHALL go to DONE with error flagged; out_rdataN SHALL be unchanged.
REQ-022 regf_ack and timer expiry in the same cycle: ack SHALL win and no error SHALL be flagged.
REQ-023 DONE: out_regf_req=0; out_ackN SHALL pulse for exactly one cycle for the winner only; out_errN SHALL pulse with it if flagged; next state SHALL be IDLE.
REQ-024 Latency: req sampled at edge t, out_regf_req high from t+1; regf_ack seen at edge k gives out_ackN high during cycle k+1; minimum 3 cycles per transaction.
REQ-025 Requesters SHALL hold reqN and their payload stable until out_ackN; inputs changed during ISSUE/DONE SHALL be ignored.
REQ-026 A reqN still high in the IDLE cycle after its ack SHALL be treated as a new transaction, so back-to-back access is permitted.
REQ-027 out_regf_req SHALL never be high in IDLE or DONE; out_regf_rw, out_regf_addr and out_regf_write_data SHALL hold their last latched value outside ISSUE.
REQ-028 regf_ack outside ISSUE SHALL be ignored.

Reset
REQ-029 With rst high at a rising edge, the block SHALL enter IDLE, abandon any transaction in flight without an ack or err pulse, and clear the timer and round-robin pointer.
REQ-030 Reset value of every output SHALL be 0: out_ack*, out_err*, out_rdata*, out_regf_*, out_busy, out_grant.

Configuration
REQ-031 Macro REGF_ARB_ROUND_ROBIN_EN defined: on simultaneous req0/req1 in IDLE, the requester not granted last SHALL win; the pointer updates in DONE; after reset requester 0 wins first.
REQ-032 Macro REGF_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties; no pointer state SHALL be implemented.

Verification
REQ-033 Single write: req1=1, rw1=1, addr1=4'h3, wdata1=8'hA5, regf_ack combinational -> out_regf_req high 1 cycle with addr 3 and data A5; out_ack1 pulses 2 cycles after req; out_err1=0.
REQ-034 Single read: req0=1, rw0=0, addr0=4'h3, regf_read_data=8'h5C -> out_rdata0=8'h5C with out_ack0; out_rdata1 unchanged.
REQ-035 Conflict: req0 and req1 held together for 4 transactions -> with the macro, grants 0,1,0,1; without it, grants 0,0,0,0 while req1 waits.
REQ-036 Timeout: regf_ack tied 0 with TIMEOUT_CYCLES=15 -> out_regf_req high exactly 15 cycles, then out_ack0 and out_err0 pulse together, then IDLE.
REQ-037 Ack on last timer cycle: regf_ack first high in ISSUE cycle 15 -> out_ack0 with out_err0=0.
REQ-038 Reset mid-ISSUE: rst asserted on ISSUE cycle 2 -> next cycle all outputs 0, no ack pulse, and the next request is served normally.
